rom_region_loader: RTL

ROM_REGION_LOADER -- requirements
Module: rom_region_loader

---
 rtl/rom_region_loader.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rom_region_loader.sv
// ROM download loader: parses region-tagged chunks and writes them to SDRAM or block RAM.
// Optional macro ROM_LOADER_CHECKSUM_EN enables the 16-bit payload checksum.

package rom_region_loader_pkg;
   typedef struct packed {
      logic [24:0] base_addr;
      logic        reorder_64;
      logic [4:0]  bram_cs;
   } region_t;
endpackage

module rom_region_loader
   import rom_region_loader_pkg::*;
#(
   parameter int                          NUM_REGIONS = 8,
   parameter region_t [NUM_REGIONS-1:0]   REGIONS     = '0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        sdr_req,
   input  logic        sdr_ack,
   output logic [24:0] sdr_addr,
   output logic [15:0] sdr_data,
   output logic [1:0]  sdr_be,
   output logic        bram_wr,
   output logic [4:0]  bram_cs,
   output logic [23:0] bram_addr,
   output logic [7:0]  bram_data,
   output logic [7:0]  board_cfg,
   output logic        done,
   output logic        error,
   output logic [15:0] checksum
);

   typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, SKIP, CFG} state_t;

   localparam logic [8:0] NUM_REGIONS_W = 9'(NUM_REGIONS);

   state_t      state_reg;
   logic        dl_prev_reg;
   logic [1:0]  hdr_cnt_reg;
   logic [7:0]  idx_reg;
   logic [23:0] len_reg;
   logic [23:0] cnt_reg;
   logic [24:0] base_reg;
   logic        reorder_reg;
   logic [4:0]  cs_reg;
   logic [21:0] qlen_reg;
   logic [21:0] qoff_reg;
   logic [1:0]  qtr_reg;
   logic [7:0]  lo_reg;
   logic        have_lo_reg;
   logic        end_pending_reg;
   logic        wait_reg;
   logic        sdr_req_reg;
   logic [24:0] sdr_addr_reg;
   logic [15:0] sdr_data_reg;
   logic [1:0]  sdr_be_reg;
   logic        bram_wr_reg;
   logic [23:0] bram_addr_reg;
   logic [7:0]  bram_data_reg;
   logic [7:0]  board_cfg_reg;
   logic        done_reg;
   logic        error_reg;

   logic        dl_rise, dl_fall, byte_valid, idx_valid, odd_byte, last_byte;
   logic [23:0] full_len, cnt_inc;
   logic [21:0] qoff_inc;
   logic [24:0] lin_sum, reo_sum, word_addr;
   region_t     sel_region;
   region_t     region_terms [NUM_REGIONS];

   // AND-OR table lookup keeps the mux flat for any NUM_REGIONS
   for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      assign region_terms[gi] = (idx_reg == 8'(gi)) ? REGIONS[gi] : '0;
   end

   always_comb begin
      sel_region = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         sel_region = sel_region | region_terms[i];
      end
   end

   assign dl_rise    = ioctl_download & ~dl_prev_reg;
   assign dl_fall    = ~ioctl_download & dl_prev_reg;
   assign byte_valid = ioctl_wr & ioctl_download;
   assign idx_valid  = {1'b0, idx_reg} < NUM_REGIONS_W;
   assign full_len   = {len_reg[23:8], ioctl_dout};
   assign cnt_inc    = cnt_reg + 24'd1;
   assign last_byte  = (cnt_inc == len_reg);
   assign qoff_inc   = qoff_reg + 22'd1;

   // Reordered word address: base + (o>>1)*8 + q*2, built from shifts only
   assign lin_sum   = base_reg + {1'b0, cnt_reg};
   assign reo_sum   = base_reg + {1'b0, qoff_reg[21:1], 3'b000} + {22'd0, qtr_reg, 1'b0};
   assign word_addr = reorder_reg ? {reo_sum[24:1], 1'b0} : {lin_sum[24:1], 1'b0};
   assign odd_byte  = reorder_reg ? qoff_reg[0] : cnt_reg[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         dl_prev_reg     <= 1'b0;
         hdr_cnt_reg     <= '0;
         idx_reg         <= '0;
         len_reg         <= '0;
         cnt_reg         <= '0;
         base_reg        <= '0;
         reorder_reg     <= 1'b0;
         cs_reg          <= '0;
         qlen_reg        <= '0;
         qoff_reg        <= '0;
         qtr_reg         <= '0;
         lo_reg          <= '0;
         have_lo_reg     <= 1'b0;
         end_pending_reg <= 1'b0;
         wait_reg        <= 1'b0;
         sdr_req_reg     <= 1'b0;
         sdr_addr_reg    <= '0;
         sdr_data_reg    <= '0;
         sdr_be_reg      <= '0;
         bram_wr_reg     <= 1'b0;
         bram_addr_reg   <= '0;
         bram_data_reg   <= '0;
         board_cfg_reg   <= '0;
         done_reg        <= 1'b0;
         error_reg       <= 1'b0;
      end else begin
         dl_prev_reg <= ioctl_download;
         bram_wr_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (dl_rise) begin
                  state_reg       <= HDR;
                  done_reg        <= 1'b0;
                  error_reg       <= 1'b0;
                  hdr_cnt_reg     <= '0;
                  have_lo_reg     <= 1'b0;
                  end_pending_reg <= 1'b0;
               end
            end
            HDR: begin
               if (dl_fall) begin
                  if (hdr_cnt_reg != 2'd0) error_reg <= 1'b1;
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end else if (byte_valid) begin
                  hdr_cnt_reg <= hdr_cnt_reg + 2'd1;
                  case (hdr_cnt_reg)
                     2'd0: idx_reg <= ioctl_dout;
                     2'd1: len_reg[23:16] <= ioctl_dout;
                     2'd2: len_reg[15:8] <= ioctl_dout;
                     default: begin
                        len_reg     <= full_len;
                        cnt_reg     <= '0;
                        qoff_reg    <= '0;
                        qtr_reg     <= '0;
                        have_lo_reg <= 1'b0;
                        base_reg    <= sel_region.base_addr;
                        cs_reg      <= sel_region.bram_cs;
                        reorder_reg <= sel_region.reorder_64 && (full_len[2:0] == 3'd0);
                        qlen_reg    <= full_len[23:2];
                        if (full_len == 24'd0) begin
                           state_reg <= HDR;
                        end else if (idx_reg == 8'hFF) begin
                           state_reg <= CFG;
                        end else if (!idx_valid) begin
                           state_reg <= SKIP;
                           error_reg <= 1'b1;
                        end else begin
                           state_reg <= DATA;
                           if (sel_region.reorder_64 && (full_len[2:0] != 3'd0)) error_reg <= 1'b1;
                        end
                     end
                  endcase
               end
            end
            DATA: begin
               if (dl_fall) begin
                  error_reg <= 1'b1;
                  if (have_lo_reg) begin
                     sdr_data_reg    <= {8'h00, lo_reg};
                     sdr_be_reg      <= 2'b01;
                     sdr_req_reg     <= 1'b1;
                     wait_reg        <= 1'b1;
                     have_lo_reg     <= 1'b0;
                     end_pending_reg <= 1'b1;
                     state_reg       <= WRITE;
                  end else begin
                     done_reg  <= 1'b1;
                     state_reg <= IDLE;
                  end
               end else if (byte_valid) begin
                  cnt_reg <= cnt_inc;
                  if (qoff_inc == qlen_reg) begin
                     qoff_reg <= '0;
                     qtr_reg  <= qtr_reg + 2'd1;
                  end else begin
                     qoff_reg <= qoff_inc;
                  end
                  if (cs_reg != 5'd0) begin
                     bram_wr_reg   <= 1'b1;
                     bram_addr_reg <= cnt_reg;
                     bram_data_reg <= ioctl_dout;
                     if (last_byte) state_reg <= HDR;
                  end else if (!odd_byte) begin
                     lo_reg       <= ioctl_dout;
                     sdr_addr_reg <= word_addr;
                     if (last_byte) begin
                        sdr_data_reg <= {8'h00, ioctl_dout};
                        sdr_be_reg   <= 2'b01;
                        sdr_req_reg  <= 1'b1;
                        wait_reg     <= 1'b1;
                        state_reg    <= WRITE;
                     end else begin
                        have_lo_reg <= 1'b1;
                     end
                  end else begin
                     sdr_data_reg <= {ioctl_dout, lo_reg};
                     sdr_be_reg   <= 2'b11;
                     sdr_req_reg  <= 1'b1;
                     wait_reg     <= 1'b1;
                     have_lo_reg  <= 1'b0;
                     state_reg    <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (dl_fall) end_pending_reg <= 1'b1;
               if (sdr_ack) begin
                  sdr_req_reg <= 1'b0;
                  wait_reg    <= 1'b0;
                  if (end_pending_reg || dl_fall) begin
                     if (cnt_reg != len_reg) error_reg <= 1'b1;
                     done_reg  <= 1'b1;
                     state_reg <= IDLE;
                  end else if (cnt_reg == len_reg) begin
                     state_reg <= HDR;
                  end else begin
                     state_reg <= DATA;
                  end
               end
            end
            SKIP, CFG: begin
               if (dl_fall) begin
                  error_reg <= 1'b1;
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end else if (byte_valid) begin
                  cnt_reg <= cnt_inc;
                  if (state_reg == CFG && cnt_reg == 24'd0) board_cfg_reg <= ioctl_dout;
                  if (last_byte) state_reg <= HDR;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef ROM_LOADER_CHECKSUM_EN
   logic [15:0] checksum_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         checksum_reg <= '0;
      end else if (state_reg == IDLE && dl_rise) begin
         checksum_reg <= '0;
      end else if (state_reg == DATA && byte_valid) begin
         checksum_reg <= checksum_reg + {8'h00, ioctl_dout};
      end
   end

   assign checksum = checksum_reg;
`else
   assign checksum = '0;
`endif

   assign ioctl_wait = wait_reg;
   assign sdr_req    = sdr_req_reg;
   assign sdr_addr   = sdr_addr_reg;
   assign sdr_data   = sdr_data_reg;
   assign sdr_be     = sdr_be_reg;
   assign bram_wr    = bram_wr_reg;
   assign bram_cs    = cs_reg;
   assign bram_addr  = bram_addr_reg;
   assign bram_data  = bram_data_reg;
   assign board_cfg  = board_cfg_reg;
   assign done       = done_reg;
   assign error      = error_reg;

endmodule
